func_request_encoder: RTL

FUNC_REQUEST_ENCODER -- requirements
Module: func_request_encoder

---
 rtl/func_request_encoder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/func_request_encoder.sv
// Captures a user code and one function key press, then presents User/Func for HOLD_CYCLES.
// Optional FUNC_REQUEST_SYNC_EN adds two-flop synchronizers on user_load, func_key and cancel.
//
// state     | meaning
// ----------+-----------------------------------------------------
// IDLE      | no request; User/Func held at 000
// WAIT_FUNC | user latched, waiting for a single function key
// HOLD      | request live on User/Func, req_valid high
module func_request_encoder #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] user_sw,
  input  logic       user_load,
  input  logic [6:0] func_key,
  input  logic       cancel,
  output logic [2:0] User,
  output logic [2:0] Func,
  output logic       req_valid,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, WAIT_FUNC, HOLD} state_t;

  state_t     state, state_nxt;
  logic       load_s, cancel_s;
  logic [6:0] key_s;
  logic       load_q;
  logic [6:0] key_q;
  logic       load_press;
  logic [6:0] key_press;
  logic [2:0] press_cnt, press_code;
  logic [7:0] to_cnt, to_cnt_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic [2:0] user_nxt, func_nxt;
  logic       err_nxt;

`ifdef FUNC_REQUEST_SYNC_EN
  logic [8:0] sync_ff1, sync_ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= {cancel, func_key, user_load};
      sync_ff2 <= sync_ff1;
    end
  end

  assign {cancel_s, key_s, load_s} = sync_ff2;
`else
  assign load_s   = user_load;
  assign key_s    = func_key;
  assign cancel_s = cancel;
`endif

  // edge registers track the inputs in every state, so keys already down
  // when WAIT_FUNC is entered never look like fresh presses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q <= 1'b0;
      key_q  <= '0;
    end else begin
      load_q <= load_s;
      key_q  <= key_s;
    end
  end

  assign load_press = load_s & ~load_q;
  assign key_press  = key_s & ~key_q;

  always_comb begin
    press_cnt  = '0;
    press_code = '0;
    for (int i = 0; i < 7; i++) begin
      if (key_press[i]) begin
        press_cnt  = press_cnt + 3'd1;
        press_code = 3'(i + 1);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    user_nxt     = User;
    func_nxt     = Func;
    err_nxt      = 1'b0;
    to_cnt_nxt   = to_cnt;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        user_nxt = '0;
        func_nxt = '0;
        if (load_press) begin
          if (user_sw == 3'b000) begin
            err_nxt = 1'b1;
          end else begin
            user_nxt   = user_sw;
            to_cnt_nxt = '0;
            state_nxt  = WAIT_FUNC;
          end
        end
      end
      WAIT_FUNC: begin
        // a valid press wins over a coincident timeout
        if (cancel_s) begin
          user_nxt  = '0;
          func_nxt  = '0;
          state_nxt = IDLE;
        end else if (press_cnt == 3'd1) begin
          func_nxt     = press_code;
          hold_cnt_nxt = '0;
          state_nxt    = HOLD;
        end else if (to_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          user_nxt  = '0;
          func_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          err_nxt    = (press_cnt > 3'd1);
          to_cnt_nxt = to_cnt + 8'd1;
        end
      end
      HOLD: begin
        if (cancel_s || hold_cnt == 8'(HOLD_CYCLES - 1)) begin
          user_nxt  = '0;
          func_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          hold_cnt_nxt = hold_cnt + 8'd1;
        end
      end
      default: begin
        user_nxt  = '0;
        func_nxt  = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      User     <= '0;
      Func     <= '0;
      err      <= 1'b0;
      to_cnt   <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      User     <= user_nxt;
      Func     <= func_nxt;
      err      <= err_nxt;
      to_cnt   <= to_cnt_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  assign req_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule
